nukv_predicate_eval_pipeline_v3: RTL and testbench

NUKV_PREDICATE_EVAL_PIPELINE_V3 -- requirements
Module: nukv_predicate_eval_pipeline_v3

---
 rtl/nukv_predicate_eval_pipeline_v3_pkg.sv | 44 ++++
 rtl/nukv_fifogen.sv | 64 ++++++
 rtl/nukv_pred_stage.sv | 134 +++++++++++++
 rtl/nukv_predicate_eval_pipeline_v3.sv | 130 +++++++++++++
 tb/tb_nukv_predicate_eval_pipeline_v3.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nukv_predicate_eval_pipeline_v3_pkg.sv
// Shared predicate definitions: field positions, op encodings and the word comparator.
package nukv_predicate_eval_pipeline_v3_pkg;

    // Bit positions inside one predicate field
    localparam int PRED_CONST_LSB = 0;
    localparam int PRED_CONST_W   = 32;
    localparam int PRED_OFF_LSB   = 32;
    localparam int PRED_OFF_W     = 8;
    localparam int PRED_OP_LSB    = 40;
    localparam int PRED_OP_W      = 3;

    typedef enum logic [2:0] {
        OP_TRUE = 3'd0,
        OP_EQ   = 3'd1,
        OP_NE   = 3'd2,
        OP_LT   = 3'd3,
        OP_GT   = 3'd4,
        OP_LE   = 3'd5,
        OP_GE   = 3'd6,
        OP_RSVD = 3'd7
    } pred_op_e;

    // Unsigned "word <op> constant"; always-true and reserved ops report true
    function automatic logic pred_compare(input pred_op_e op, input logic [31:0] word,
                                          input logic [31:0] pconst);
        logic res;
        case (op)
            OP_EQ:   res = (word == pconst);
            OP_NE:   res = (word != pconst);
            OP_LT:   res = (word <  pconst);
            OP_GT:   res = (word >  pconst);
            OP_LE:   res = (word <= pconst);
            OP_GE:   res = (word >= pconst);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    // Ops that never inspect the value (their offset is irrelevant)
    function automatic logic op_is_trivial(input pred_op_e op);
        return (op == OP_TRUE) || (op == OP_RSVD);
    endfunction

endpackage

// File: rtl/nukv_fifogen.sv
// First-word-fall-through FIFO: array storage with a registered read into a head register.
module nukv_fifogen #(
    parameter int WIDTH     = 144,
    parameter int ADDR_BITS = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS+1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_BITS:0]   mem_count_reg;
    logic [WIDTH-1:0]     dout_reg;
    logic                 dout_valid_reg;
    logic                 pop, head_free, load_mem, bypass, write_mem;

    assign pop       = dout_valid_reg & rd_en;
    assign head_free = !dout_valid_reg | pop;
    assign load_mem  = head_free & (mem_count_reg != '0);
    // With nothing stored, a write lands straight in the head register
    assign bypass    = head_free & (mem_count_reg == '0) & wr_en;
    assign write_mem = wr_en & !bypass;

    assign wr_ready = (mem_count_reg != DEPTH_CNT);
    assign rd_data  = dout_reg;
    assign rd_valid = dout_valid_reg;

    // Storage array and registered head read
    always_ff @(posedge clk) begin
        if (write_mem)
            mem[wr_ptr_reg] <= wr_data;
        if (load_mem)
            dout_reg <= mem[rd_ptr_reg];
        else if (bypass)
            dout_reg <= wr_data;
    end

    // Pointers, occupancy and head-valid tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            mem_count_reg  <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            if (write_mem)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (load_mem)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            mem_count_reg  <= mem_count_reg + {{ADDR_BITS{1'b0}}, write_mem}
                                            - {{ADDR_BITS{1'b0}}, load_mem};
            dout_valid_reg <= load_mem | bypass | (dout_valid_reg & !pop);
        end
    end

endmodule

// File: rtl/nukv_pred_stage.sv
// One predicate stage: config FIFO, word comparator and a valid/ready register slice.
module nukv_pred_stage
    import nukv_predicate_eval_pipeline_v3_pkg::*;
#(
    parameter int MEMORY_WIDTH   = 512,
    parameter int META_WIDTH     = 96,
    parameter int PRED_WIDTH     = 48,
    parameter int FIFO_ADDR_BITS = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    input  logic [PRED_WIDTH-1:0]   cfg_pred,
    input  logic [META_WIDTH-1:0]   cfg_meta,
    output logic                    cfg_ready,
    input  logic [MEMORY_WIDTH-1:0] in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic                    in_drop,
    output logic                    in_ready,
    output logic [MEMORY_WIDTH-1:0] out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic                    out_drop,
    output logic [META_WIDTH-1:0]   out_meta,
    input  logic                    out_ready
);
    localparam int WPB   = MEMORY_WIDTH / 32;
    localparam int CFG_W = PRED_WIDTH + META_WIDTH;

    logic [CFG_W-1:0]        cfg_head;
    logic                    cfg_head_valid, cfg_pop;
    logic [PRED_WIDTH-1:0]   head_pred;
    logic [META_WIDTH-1:0]   head_meta;
    pred_op_e                op;
    logic [7:0]              off, diff;
    logic [31:0]             pred_const, sel_word;
    logic                    hit, trivial, beat_fail, unreached, in_fire, drop_eval;
    logic [31:0]             beat_words [WPB];

    logic [7:0]              word_base_reg;
    logic                    fail_reg, reached_reg;
    logic                    valid_reg, last_reg, drop_reg;
    logic [MEMORY_WIDTH-1:0] data_reg;
    logic [META_WIDTH-1:0]   meta_reg;

    nukv_fifogen #(.WIDTH(CFG_W), .ADDR_BITS(FIFO_ADDR_BITS)) u_cfg_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cfg_valid),
        .wr_data  ({cfg_pred, cfg_meta}),
        .wr_ready (cfg_ready),
        .rd_en    (cfg_pop),
        .rd_data  (cfg_head),
        .rd_valid (cfg_head_valid)
    );

    assign head_pred  = cfg_head[CFG_W-1:META_WIDTH];
    assign head_meta  = cfg_head[META_WIDTH-1:0];
    assign op         = pred_op_e'(head_pred[PRED_OP_LSB +: PRED_OP_W]);
    assign off        = head_pred[PRED_OFF_LSB +: PRED_OFF_W];
    assign pred_const = head_pred[PRED_CONST_LSB +: PRED_CONST_W];

    generate
        for (genvar gi = 0; gi < WPB; gi++) begin : g_words
            assign beat_words[gi] = in_data[gi*32 +: 32];
        end
    endgenerate

    // Pick the addressed word out of the current beat
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < WPB; k++)
            if (int'(diff) == k)
                sel_word = beat_words[k];
    end

    assign diff      = off - word_base_reg;
    assign hit       = (int'(diff) < WPB);
    assign trivial   = op_is_trivial(op);
    assign beat_fail = !trivial & hit & !pred_compare(op, sel_word, pred_const);
    // Offset beyond the value's end: the predicate cannot hold
    assign unreached = !trivial & !reached_reg & !hit;
    assign drop_eval = in_last ? (in_drop | fail_reg | beat_fail | unreached) : in_drop;

    // No predicate loaded means no way to judge the beat, so hold it off
    assign in_ready = cfg_head_valid & (!valid_reg | out_ready);
    assign in_fire  = in_valid & in_ready;
    // The verdict travels with the beat, so the entry can retire as the last beat enters
    assign cfg_pop  = in_fire & in_last;

    // Per-value word-base, sticky fail and reached tracking plus slice valid
    always_ff @(posedge clk) begin
        if (rst) begin
            word_base_reg <= '0;
            fail_reg      <= 1'b0;
            reached_reg   <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            if (in_fire) begin
                if (in_last) begin
                    word_base_reg <= '0;
                    fail_reg      <= 1'b0;
                    reached_reg   <= 1'b0;
                end else begin
                    word_base_reg <= word_base_reg + 8'(WPB);
                    fail_reg      <= fail_reg | beat_fail;
                    reached_reg   <= reached_reg | hit;
                end
            end
            if (in_fire)
                valid_reg <= 1'b1;
            else if (out_ready)
                valid_reg <= 1'b0;
        end
    end

    // Slice payload
    always_ff @(posedge clk) begin
        if (in_fire) begin
            data_reg <= in_data;
            last_reg <= in_last;
            drop_reg <= drop_eval;
            meta_reg <= head_meta;
        end
    end

    assign out_data  = data_reg;
    assign out_valid = valid_reg;
    assign out_last  = last_reg;
    assign out_drop  = drop_reg;
    assign out_meta  = meta_reg;

endmodule

// File: rtl/nukv_predicate_eval_pipeline_v3.sv
// Predicate evaluation pipeline: chain of predicate stages, command generation and counters.
module nukv_predicate_eval_pipeline_v3
    import nukv_predicate_eval_pipeline_v3_pkg::*;
#(
    parameter int MEMORY_WIDTH      = 512,
    parameter int META_WIDTH        = 96,
    parameter int NUM_STAGES        = 4,
    parameter int PRED_WIDTH        = 48,
    parameter int FIFO_ADDR_BITS    = 7,
    parameter int GENERATE_COMMANDS = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [META_WIDTH+NUM_STAGES*PRED_WIDTH-1:0] pred_data,
    input  logic                                     pred_valid,
    output logic                                     pred_ready,
    input  logic [MEMORY_WIDTH-1:0]                  value_data,
    input  logic                                     value_valid,
    input  logic                                     value_last,
    input  logic                                     value_drop,
    output logic                                     value_ready,
    output logic [MEMORY_WIDTH-1:0]                  output_data,
    output logic                                     output_valid,
    output logic                                     output_last,
    output logic                                     output_drop,
    input  logic                                     output_ready,
    output logic                                     cmd_valid,
    output logic [15:0]                              cmd_length,
    output logic [META_WIDTH-1:0]                    cmd_meta,
    input  logic                                     cmd_ready,
    output logic [31:0]                              pass_count,
    output logic [31:0]                              drop_count,
    output logic                                     error_input
);
    logic [NUM_STAGES-1:0]   cfg_ready_vec, op_rsvd_vec;
    logic [NUM_STAGES:0]     link_valid, link_last, link_drop, link_ready;
    logic [MEMORY_WIDTH-1:0] link_data  [NUM_STAGES+1];
    logic [META_WIDTH-1:0]   stage_meta [NUM_STAGES];
    logic                    pred_fire, need_cmd, out_fire;
    logic [31:0]             beats_total;

    logic [15:0]             beat_cnt_reg;
    logic [31:0]             pass_count_reg, drop_count_reg;
    logic                    error_reg;

    assign pred_ready = &cfg_ready_vec;
    assign pred_fire  = pred_valid & pred_ready;

    assign link_data[0]  = value_data;
    assign link_valid[0] = value_valid;
    assign link_last[0]  = value_last;
    assign link_drop[0]  = value_drop;
    assign value_ready   = link_ready[0];

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            assign op_rsvd_vec[gi] =
                (pred_op_e'(pred_data[META_WIDTH + gi*PRED_WIDTH + PRED_OP_LSB +: PRED_OP_W]) == OP_RSVD);

            nukv_pred_stage #(
                .MEMORY_WIDTH   (MEMORY_WIDTH),
                .META_WIDTH     (META_WIDTH),
                .PRED_WIDTH     (PRED_WIDTH),
                .FIFO_ADDR_BITS (FIFO_ADDR_BITS)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .cfg_valid (pred_fire),
                .cfg_pred  (pred_data[META_WIDTH + gi*PRED_WIDTH +: PRED_WIDTH]),
                .cfg_meta  (pred_data[META_WIDTH-1:0]),
                .cfg_ready (cfg_ready_vec[gi]),
                .in_data   (link_data[gi]),
                .in_valid  (link_valid[gi]),
                .in_last   (link_last[gi]),
                .in_drop   (link_drop[gi]),
                .in_ready  (link_ready[gi]),
                .out_data  (link_data[gi+1]),
                .out_valid (link_valid[gi+1]),
                .out_last  (link_last[gi+1]),
                .out_drop  (link_drop[gi+1]),
                .out_meta  (stage_meta[gi]),
                .out_ready (link_ready[gi+1])
            );
        end
    endgenerate

    // A passing last beat leaves only together with its command
    assign need_cmd     = (GENERATE_COMMANDS != 0) && link_last[NUM_STAGES] && !link_drop[NUM_STAGES];
    assign output_valid = link_valid[NUM_STAGES] & (!need_cmd | cmd_ready);
    assign cmd_valid    = link_valid[NUM_STAGES] & need_cmd & output_ready;
    assign link_ready[NUM_STAGES] = output_ready & (!need_cmd | cmd_ready);
    assign out_fire     = output_valid & output_ready;

    assign output_data = link_data[NUM_STAGES];
    assign output_last = link_last[NUM_STAGES];
    assign output_drop = link_drop[NUM_STAGES];

    assign beats_total = {16'b0, beat_cnt_reg} + 32'd1;
    assign cmd_length  = 16'(beats_total * 32'(MEMORY_WIDTH/8));
    assign cmd_meta    = stage_meta[NUM_STAGES-1];

    assign pass_count  = pass_count_reg;
    assign drop_count  = drop_count_reg;
    assign error_input = error_reg;

    // Output-side beat count, completion counters and sticky reserved-op flag
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_reg   <= '0;
            pass_count_reg <= '0;
            drop_count_reg <= '0;
            error_reg      <= 1'b0;
        end else begin
            if (out_fire) begin
                if (output_last) begin
                    beat_cnt_reg <= '0;
                    if (output_drop)
                        drop_count_reg <= drop_count_reg + 32'd1;
                    else
                        pass_count_reg <= pass_count_reg + 32'd1;
                end else begin
                    beat_cnt_reg <= beat_cnt_reg + 16'd1;
                end
            end
            if (pred_fire && (|op_rsvd_vec))
                error_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nukv_predicate_eval_pipeline_v3.sv
// Scoreboard bench: directed predicate/value vectors, monitor compares outputs and commands.
module tb_nukv_predicate_eval_pipeline_v3;
    localparam int MW = 512;
    localparam int MT = 96;
    localparam int NS = 2;
    localparam int PW = 48;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [MT+NS*PW-1:0] pred_data = '0;
    logic              pred_valid = 1'b0, pred_ready;
    logic [MW-1:0]     value_data = '0;
    logic              value_valid = 1'b0, value_last = 1'b0, value_drop = 1'b0, value_ready;
    logic [MW-1:0]     output_data;
    logic              output_valid, output_last, output_drop;
    logic              output_ready = 1'b1;
    logic              cmd_valid;
    logic [15:0]       cmd_length;
    logic [MT-1:0]     cmd_meta;
    logic              cmd_ready = 1'b1;
    logic [31:0]       pass_count, drop_count;
    logic              error_input;

    nukv_predicate_eval_pipeline_v3 #(
        .MEMORY_WIDTH(MW), .META_WIDTH(MT), .NUM_STAGES(NS), .PRED_WIDTH(PW),
        .FIFO_ADDR_BITS(4), .GENERATE_COMMANDS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .pred_data(pred_data), .pred_valid(pred_valid), .pred_ready(pred_ready),
        .value_data(value_data), .value_valid(value_valid), .value_last(value_last),
        .value_drop(value_drop), .value_ready(value_ready),
        .output_data(output_data), .output_valid(output_valid), .output_last(output_last),
        .output_drop(output_drop), .output_ready(output_ready),
        .cmd_valid(cmd_valid), .cmd_length(cmd_length), .cmd_meta(cmd_meta), .cmd_ready(cmd_ready),
        .pass_count(pass_count), .drop_count(drop_count), .error_input(error_input)
    );

    always #5 clk = ~clk;

    typedef struct { logic [MW-1:0] data; bit last; bit drop; } beat_t;
    typedef struct { logic [15:0] len; logic [MT-1:0] meta; } cmd_t;
    beat_t exp_q[$];
    cmd_t  cmd_q[$];
    int    out_cycles[$];
    int    checks = 0, errors = 0;
    int    cyc = 0;
    int    first_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else
            $display("ok   %s: 0x%0h", name, act);
    endtask

    // Monitor: every output transfer is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (!rst) begin
            if (output_valid && output_ready) begin
                checks++;
                out_cycles.push_back(cyc);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got last=%0b drop=%0b expected none", output_last, output_drop);
                end else begin
                    beat_t e;
                    bit want_cmd;
                    e = exp_q.pop_front();
                    if (output_data !== e.data || output_last !== e.last || output_drop !== e.drop) begin
                        errors++;
                        $display("FAIL beat: got last=%0b drop=%0b w0=0x%0h expected last=%0b drop=%0b w0=0x%0h",
                                 output_last, output_drop, output_data[31:0], e.last, e.drop, e.data[31:0]);
                    end else
                        $display("beat ok: last=%0b drop=%0b", output_last, output_drop);
                    want_cmd = e.last && !e.drop;
                    checks++;
                    if ((cmd_valid && cmd_ready) !== want_cmd) begin
                        errors++;
                        $display("FAIL cmd_presence: got %0b expected %0b", cmd_valid && cmd_ready, want_cmd);
                    end else if (want_cmd) begin
                        cmd_t c;
                        c = cmd_q.pop_front();
                        checks++;
                        if (cmd_length !== c.len || cmd_meta !== c.meta) begin
                            errors++;
                            $display("FAIL cmd: got len=%0d meta=0x%0h expected len=%0d meta=0x%0h",
                                     cmd_length, cmd_meta, c.len, c.meta);
                        end else
                            $display("cmd ok: len=%0d meta=0x%0h", cmd_length, cmd_meta);
                    end
                end
            end else if (cmd_valid && cmd_ready) begin
                checks++;
                errors++;
                $display("FAIL cmd_without_beat: got len=%0d expected no cmd", cmd_length);
            end
        end
    end

    function automatic logic [PW-1:0] mk_pred(input logic [2:0] op, input logic [7:0] off, input logic [31:0] c);
        return {5'b0, op, off, c};
    endfunction

    task automatic send_pred(input logic [MT-1:0] meta, input logic [PW-1:0] p0, input logic [PW-1:0] p1);
        int n = 0;
        pred_data  = {p1, p0, meta};
        pred_valid = 1'b1;
        while (!pred_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin checks++; errors++; $display("FAIL pred_timeout: got ready=0 expected 1"); end
        @(negedge clk);
        pred_valid = 1'b0;
        $display("pred set meta=0x%0h accepted", meta);
    endtask

    // Pushes expectations, then drives the beats; leaves value_valid high for back-to-back use
    task automatic send_value(input int nb, input int i0, input logic [31:0] v0, input int i1,
                              input logic [31:0] v1, input bit drop_last, input bit exp_drop,
                              input logic [MT-1:0] meta);
        logic [MW-1:0] beats [4];
        beat_t e;
        cmd_t  c;
        for (int b = 0; b < nb; b++) begin
            beats[b] = '0;
            if (i0 >= 0 && i0 / 16 == b) beats[b][(i0 % 16)*32 +: 32] = v0;
            if (i1 >= 0 && i1 / 16 == b) beats[b][(i1 % 16)*32 +: 32] = v1;
            e.data = beats[b];
            e.last = (b == nb - 1);
            e.drop = e.last ? exp_drop : 1'b0;
            exp_q.push_back(e);
        end
        if (!exp_drop) begin
            c.len  = 16'(nb * 64);
            c.meta = meta;
            cmd_q.push_back(c);
        end
        for (int b = 0; b < nb; b++) begin
            int n = 0;
            value_valid = 1'b1;
            value_data  = beats[b];
            value_last  = (b == nb - 1);
            value_drop  = (b == nb - 1) ? drop_last : 1'b0;
            while (!value_ready && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) begin checks++; errors++; $display("FAIL value_timeout: got ready=0 expected 1"); end
            if (b == 0) first_acc = cyc;
            @(negedge clk);
        end
        $display("value issued: beats=%0d expect drop=%0b", nb, exp_drop);
    endtask

    task automatic drain();
        int n = 0;
        value_valid = 1'b0;
        while ((exp_q.size() != 0 || cmd_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        bit stall_ok;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_pred_ready", 32'(pred_ready), 32'd1);
        check("reset_output_valid", 32'(output_valid), 32'd0);
        check("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset_pass_count", pass_count, 32'd0);
        check("reset_drop_count", drop_count, 32'd0);
        check("reset_error_input", 32'(error_input), 32'd0);

        // EQ word0 == 5, passing single beat
        send_pred(96'h1, mk_pred(3'd1, 8'd0, 32'h5), mk_pred(3'd0, 8'd0, 32'h0));
        check("value_ready_loaded", 32'(value_ready), 32'd1);
        send_value(1, 0, 32'h5, -1, 32'h0, 1'b0, 1'b0, 96'h1);
        drain();
        check("eq_pass_count", pass_count, 32'd1);

        // EQ mismatch
        send_pred(96'h2, mk_pred(3'd1, 8'd0, 32'h5), mk_pred(3'd0, 8'd0, 32'h0));
        send_value(1, 0, 32'h6, -1, 32'h0, 1'b0, 1'b1, 96'h2);
        drain();
        check("eq_drop_count", drop_count, 32'd1);

        // GT on word 20, second beat
        send_pred(96'h3, mk_pred(3'd4, 8'd20, 32'd9), mk_pred(3'd0, 8'd0, 32'h0));
        send_value(2, 20, 32'd10, -1, 32'h0, 1'b0, 1'b0, 96'h3);
        drain();
        check("gt_pass_count", pass_count, 32'd2);

        // Offset 40 never reached in 32 words
        send_pred(96'h4, mk_pred(3'd1, 8'd40, 32'h0), mk_pred(3'd0, 8'd0, 32'h0));
        send_value(2, -1, 32'h0, -1, 32'h0, 1'b0, 1'b1, 96'h4);
        drain();
        check("unreached_drop_count", drop_count, 32'd2);

        // Reserved op: flags error, evaluates true
        check("error_before_rsvd", 32'(error_input), 32'd0);
        send_pred(96'h5, mk_pred(3'd7, 8'd0, 32'h1234), mk_pred(3'd0, 8'd0, 32'h0));
        send_value(1, 0, 32'h0, -1, 32'h0, 1'b0, 1'b0, 96'h5);
        drain();
        check("error_after_rsvd", 32'(error_input), 32'd1);
        check("rsvd_pass_count", pass_count, 32'd3);

        // Second stage LT fails (100 < 100 false)
        send_pred(96'h6, mk_pred(3'd0, 8'd0, 32'h0), mk_pred(3'd3, 8'd3, 32'd100));
        send_value(1, 3, 32'd100, -1, 32'h0, 1'b0, 1'b1, 96'h6);
        drain();
        check("lt_drop_count", drop_count, 32'd3);

        // GE on beat 2 and NE on beat 1 both hold
        send_pred(96'h7, mk_pred(3'd6, 8'd17, 32'h8000_0000), mk_pred(3'd2, 8'd3, 32'd7));
        send_value(2, 17, 32'hFFFF_FFFF, 3, 32'd8, 1'b0, 1'b0, 96'h7);
        drain();
        check("ge_ne_pass_count", pass_count, 32'd4);

        // LE holds but the incoming drop flag forces a drop
        send_pred(96'h8, mk_pred(3'd5, 8'd3, 32'd100), mk_pred(3'd0, 8'd0, 32'h0));
        send_value(1, 3, 32'd100, -1, 32'h0, 1'b1, 1'b1, 96'h8);
        drain();
        check("le_indrop_drop_count", drop_count, 32'd4);

        // Back-to-back values with preloaded predicates
        send_pred(96'h9, mk_pred(3'd1, 8'd1, 32'hAA), mk_pred(3'd0, 8'd0, 32'h0));
        send_pred(96'hA, mk_pred(3'd2, 8'd18, 32'd3), mk_pred(3'd0, 8'd0, 32'h0));
        send_pred(96'hB, mk_pred(3'd0, 8'd0, 32'h0), mk_pred(3'd4, 8'd5, 32'd0));
        out_cycles.delete();
        send_value(1, 1, 32'hAA, -1, 32'h0, 1'b0, 1'b0, 96'h9);
        n = first_acc;
        send_value(2, 18, 32'd3, -1, 32'h0, 1'b0, 1'b1, 96'hA);
        send_value(1, 5, 32'd1, -1, 32'h0, 1'b0, 1'b0, 96'hB);
        drain();
        check("b2b_beat_count", 32'(out_cycles.size()), 32'd4);
        if (out_cycles.size() == 4) begin
            check("b2b_throughput_span", 32'(out_cycles[3] - out_cycles[0]), 32'd3);
            check("zero_stall_latency", 32'(out_cycles[0] - n), 32'(NS));
        end
        check("b2b_pass_count", pass_count, 32'd6);
        check("b2b_drop_count", drop_count, 32'd5);

        // Command backpressure holds the passing last beat
        cmd_ready = 1'b0;
        send_pred(96'h77, mk_pred(3'd1, 8'd0, 32'h5), mk_pred(3'd0, 8'd0, 32'h0));
        send_value(1, 0, 32'h5, -1, 32'h0, 1'b0, 1'b0, 96'h77);
        value_valid = 1'b0;
        n = 0;
        while (!cmd_valid && n < 50) begin @(negedge clk); n++; end
        check("stall_cmd_pending", 32'(cmd_valid), 32'd1);
        stall_ok = 1'b1;
        repeat (5) begin
            if (output_valid || !cmd_valid) stall_ok = 1'b0;
            @(negedge clk);
        end
        check("stall_output_held", 32'(stall_ok), 32'd1);
        cmd_ready = 1'b1;
        drain();
        check("stall_pass_count", pass_count, 32'd7);
        check("error_still_set", 32'(error_input), 32'd1);

        // Reset in the middle of a two-beat value
        send_pred(96'hC, mk_pred(3'd1, 8'd0, 32'h5), mk_pred(3'd0, 8'd0, 32'h0));
        begin
            beat_t e;
            e.data = '0; e.data[31:0] = 32'h5; e.last = 1'b0; e.drop = 1'b0;
            exp_q.push_back(e);
            value_valid = 1'b1; value_data = e.data; value_last = 1'b0; value_drop = 1'b0;
            n = 0;
            while (!value_ready && n < 100) begin @(negedge clk); n++; end
            @(negedge clk);
            value_valid = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        cmd_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_pass_count", pass_count, 32'd0);
        check("rst_mid_drop_count", drop_count, 32'd0);
        check("rst_mid_error", 32'(error_input), 32'd0);
        check("rst_mid_output_valid", 32'(output_valid), 32'd0);
        check("rst_mid_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_mid_pred_ready", 32'(pred_ready), 32'd1);
        repeat (5) @(negedge clk);

        // Pipeline usable again after reset
        send_pred(96'hD, mk_pred(3'd1, 8'd0, 32'h5), mk_pred(3'd0, 8'd0, 32'h0));
        send_value(1, 0, 32'h5, -1, 32'h0, 1'b0, 1'b0, 96'hD);
        drain();
        check("post_rst_pass_count", pass_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
